// File: rtl/rf_arb_pkg.sv
// Shared widths and the holding-buffer entry type for the register-file
// write arbiter.
package rf_arb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } bufEntry_t;

  // A request only counts when it targets a real register; r0 writes vanish.
  function automatic logic isLive(input logic we, input logic [REG_W-1:0] rd);
    return we && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// In-order holding buffer for mult/div results that lost the write port.
// Entries stay packed toward slot 0, so slot 0 is always the head.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pop,
  input  logic              push,
  input  logic [REG_W-1:0]  pushRd,
  input  logic [DATA_W-1:0] pushData,
  input  logic              squashEn,
  input  logic [REG_W-1:0]  squashRd,
  output logic [REG_W-1:0]  headRd,
  output logic [DATA_W-1:0] headData,
  output logic [CNT_W-1:0]  count,
  output logic [31:0]       pendMask
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  bufEntry_t        entries     [DEPTH];
  bufEntry_t        nextEntries [DEPTH];
  logic [CNT_W-1:0] nextCount;

  // Popped and squashed entries drop out, survivors close ranks in arrival
  // order, and the new push lands right behind them.
  always_comb begin
    nextCount = '0;
    for (int i = 0; i < DEPTH; i++) nextEntries[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && !(pop && i == 0) &&
          !(squashEn && entries[i].rd == squashRd)) begin
        nextEntries[nextCount[IDX_W-1:0]] = entries[i];
        nextCount = nextCount + 1'b1;
      end
    end
    if (push && nextCount < DEPTH_C) begin
      nextEntries[nextCount[IDX_W-1:0]] = {1'b1, pushRd, pushData};
      nextCount = nextCount + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entries <= '{default: '0};
      count   <= '0;
    end else begin
      entries <= nextEntries;
      count   <= nextCount;
    end
  end

  always_comb begin
    pendMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid) pendMask[entries[i].rd] = 1'b1;
    end
    pendMask[0] = 1'b0;
  end

  assign headRd   = entries[0].rd;
  assign headData = entries[0].data;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared by MW writeback and mult/div results.
// Optional same-cycle mult/div bypass: define RF_ARB_MD_BYPASS_EN.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mw_we,
  input  logic [REG_W-1:0]  mw_rd,
  input  logic [DATA_W-1:0] mw_data,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_wd,
  output logic [DATA_W-1:0] rf_data,
  output logic              pipe_stall,
  output logic [31:0]       pend_mask,
  output logic [CNT_W-1:0]  buf_count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic              mwLive, mdLive, bufEmpty, bufFull;
  logic              pop, push, mwCommit, bypass;
  logic [REG_W-1:0]  headRd;
  logic [DATA_W-1:0] headData;

  assign mwLive   = isLive(mw_we, mw_rd);
  assign mdLive   = isLive(md_valid, md_rd);
  assign bufEmpty = (buf_count == '0);
  assign bufFull  = (buf_count == FULL);

  // Handshake: md_valid is a fire-and-forget pulse that is always accepted
  // (written, bypassed or buffered); MW has no valid/ready pair of its own,
  // pipe_stall=1 means "not taken, present the same request next cycle".
  always_comb begin
    rf_we      = 1'b0;
    rf_wd      = '0;
    rf_data    = '0;
    pipe_stall = 1'b0;
    pop        = 1'b0;
    mwCommit   = 1'b0;
    bypass     = 1'b0;
    if (!bufEmpty && (bufFull || !mwLive)) begin
      rf_we      = 1'b1;
      rf_wd      = headRd;
      rf_data    = headData;
      pop        = 1'b1;
      pipe_stall = mwLive;
    end else if (mwLive) begin
      rf_we    = 1'b1;
      rf_wd    = mw_rd;
      rf_data  = mw_data;
      mwCommit = 1'b1;
    end
`ifdef RF_ARB_MD_BYPASS_EN
    else if (mdLive && bufEmpty) begin
      rf_we   = 1'b1;
      rf_wd   = md_rd;
      rf_data = md_data;
      bypass  = 1'b1;
    end
`endif
    push = mdLive && !bypass;
  end

  // An MW commit to r makes any older buffered result for r stale.
  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .pop      (pop),
    .push     (push),
    .pushRd   (md_rd),
    .pushData (md_data),
    .squashEn (mwCommit),
    .squashRd (mw_rd),
    .headRd   (headRd),
    .headData (headData),
    .count    (buf_count),
    .pendMask (pend_mask)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios plus random
// traffic, checked against a queue-based model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef RF_ARB_MD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clock, reset;
  logic          mw_we, md_valid;
  logic [4:0]    mw_rd, md_rd;
  logic [31:0]   mw_data, md_data;
  logic          rf_we, pipe_stall;
  logic [4:0]    rf_wd;
  logic [31:0]   rf_data, pend_mask;
  logic [CW-1:0] buf_count;

  typedef struct packed {
    logic          we;
    logic          stall;
    logic [CW-1:0] cnt;
    logic [31:0]   mask;
  } cyc_t;

  logic [36:0] exp_q[$];   // expected port writes {rd, data}
  cyc_t        cyc_q[$];   // expected per-cycle status
  logic [36:0] pend_q[$];  // model of results waiting for the port
  int          tests = 0;
  int          fails = 0;
  bit          stalled = 1'b0;

  regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .mw_we      (mw_we),
    .mw_rd      (mw_rd),
    .mw_data    (mw_data),
    .md_valid   (md_valid),
    .md_rd      (md_rd),
    .md_data    (md_data),
    .rf_we      (rf_we),
    .rf_wd      (rf_wd),
    .rf_data    (rf_data),
    .pipe_stall (pipe_stall),
    .pend_mask  (pend_mask),
    .buf_count  (buf_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- driver + reference model ----------------
  task automatic drive_cycle(input logic mwe, input logic [4:0] mrd, input logic [31:0] mdat,
                             input logic mdv, input logic [4:0] drd, input logic [31:0] ddat);
    cyc_t e;
    bit   mwl, mdl, byp;
    @(posedge clock);
    #1;
    mw_we = mwe; mw_rd = mrd; mw_data = mdat;
    md_valid = mdv; md_rd = drd; md_data = ddat;
    mwl = mwe && (mrd != 5'd0);
    mdl = mdv && (drd != 5'd0);
    byp = 1'b0;
    e.we = 1'b0;
    e.stall = 1'b0;
    e.cnt = CW'(pend_q.size());
    e.mask = '0;
    foreach (pend_q[i]) e.mask[pend_q[i][36:32]] = 1'b1;
    if (pend_q.size() > 0 && (pend_q.size() == DEPTH || !mwl)) begin
      e.we = 1'b1;
      e.stall = mwl;
      exp_q.push_back(pend_q.pop_front());
    end else if (mwl) begin
      e.we = 1'b1;
      exp_q.push_back({mrd, mdat});
      for (int i = pend_q.size() - 1; i >= 0; i--)
        if (pend_q[i][36:32] == mrd) pend_q.delete(i);
    end else if (BYPASS && mdl && pend_q.size() == 0) begin
      e.we = 1'b1;
      byp = 1'b1;
      exp_q.push_back({drd, ddat});
    end
    if (mdl && !byp) pend_q.push_back({drd, ddat});
    stalled = e.stall;
    cyc_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Reset lands mid-cycle while MW is waiting behind a full buffer.
  task automatic mid_reset(input logic [4:0] mrd, input logic [31:0] mdat);
    @(posedge clock);
    #1;
    mw_we = 1'b1; mw_rd = mrd; mw_data = mdat;
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    #1;
    check("pre_reset_stall", pipe_stall, (pend_q.size() == DEPTH) ? 1 : 0);
    #1;
    reset = 1'b1;
    #1;
    check("reset_buf_count", buf_count, 0);
    check("reset_pend_mask", pend_mask, 0);
    check("reset_pipe_stall", pipe_stall, 0);
    pend_q.delete();
    stalled = 1'b0;
    exp_q.push_back({mrd, mdat});
    cyc_q.push_back('{we: 1'b1, stall: 1'b0, cnt: '0, mask: '0});
    @(negedge clock);
    #1;
    reset = 1'b0;
    mw_we = 1'b0; mw_rd = 5'd0; mw_data = 32'd0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    cyc_t        c;
    logic [36:0] w;
    forever begin
      @(negedge clock);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("rf_we", rf_we, c.we);
        check("pipe_stall", pipe_stall, c.stall);
        check("buf_count", buf_count, c.cnt);
        check("pend_mask", pend_mask, c.mask);
        if (!c.we) check("idle_port", {rf_wd, rf_data}, 0);
      end
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: actual r%0d=%0h required no write", rf_wd, rf_data);
        end else begin
          w = exp_q.pop_front();
          check("write", {rf_wd, rf_data}, w);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        mwe, mdv;
    logic [4:0]  mrd, drd;
    logic [31:0] mdat, ddat;
    reset = 1'b1;
    mw_we = 1'b0; mw_rd = '0; mw_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
    repeat (2) @(posedge clock);
    #2;
    check("init_buf_count", buf_count, 0);
    check("init_pend_mask", pend_mask, 0);
    check("init_pipe_stall", pipe_stall, 0);
    check("init_port", {rf_we, rf_wd, rf_data}, 0);
    @(negedge clock);
    #1;
    reset = 1'b0;

    // bypass (or one-cycle buffering) of a lone result
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    idle(2);
    // MW wins, result follows next cycle
    drive_cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
    idle(2);
    // fill with r8, r9; a fresh result keeps it full so MW r4 stalls twice
    drive_cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'h88);
    drive_cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
    drive_cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hCC);
    drive_cycle(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
    drive_cycle(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
    idle(3);
    // WAW squash of a buffered r6
    drive_cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd6, 32'h66);
    drive_cycle(1'b1, 5'd6, 32'h55, 1'b0, 5'd0, 32'd0);
    idle(2);
    // r0 requests vanish
    drive_cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    idle(1);
    // reset with two results pending
    drive_cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'hA0);
    drive_cycle(1'b1, 5'd2, 32'h202, 1'b1, 5'd11, 32'hB0);
    mid_reset(5'd4, 32'h444);
    idle(4);

    // random traffic; a stalled MW request is re-presented unchanged
    mwe = 1'b0; mrd = '0; mdat = '0;
    for (int n = 0; n < 400; n++) begin
      if (!stalled) begin
        mwe  = ($urandom_range(0, 99) < 55);
        mrd  = 5'($urandom_range(0, 9));
        mdat = $urandom;
      end
      mdv  = ($urandom_range(0, 99) < 45);
      drd  = 5'($urandom_range(0, 9));
      ddat = $urandom;
      drive_cycle(mwe, mrd, mdat, mdv, drd, ddat);
    end
    idle(DEPTH + 2);
    @(negedge clock);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("final_buf_count", buf_count, pend_q.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
